// File: rtl/rtl_settings_pkg.sv
// Shared settings for the memory test controller: bus widths, mode and
// state enums, and the LFSR feedback taps used for random addressing.
package rtl_settings_pkg;

  // Avalon-MM address width and burst-count width of the memory under test.
  localparam int CMP_ADDR_W  = 26;
  localparam int AMM_BURST_W = 11;

  typedef enum logic [1:0] {
    READ_ONLY       = 2'd0,
    WRITE_ONLY      = 2'd1,
    WRITE_AND_CHECK = 2'd2
  } test_mode_t;

  typedef enum logic [2:0] {
    RND   = 3'd0,
    FIX   = 3'd1,
    INC   = 3'd2,
    RUN_0 = 3'd3,
    RUN_1 = 3'd4
  } addr_mode_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_ISSUE = 3'd1,
    WR_WAIT  = 3'd2,
    RD_ISSUE = 3'd3,
    RD_WAIT  = 3'd4,
    FINISH   = 3'd5
  } mem_test_state_t;

  // Right-shifting Galois feedback mask for x^26 + x^6 + x^2 + x + 1.
  localparam logic [25:0] LFSR_TAPS = 26'h200_0023;

endpackage

// File: rtl/mem_test_ctrl_if.sv
// Command bus between the test controller (master) and the transaction
// generator/comparator (slave), plus the phase-complete pulse back.
interface mem_test_ctrl_if;
  import rtl_settings_pkg::*;

  logic                   cmd_valid_o;
  logic                   cmd_ready_i;
  logic                   cmd_write_o;
  logic [CMP_ADDR_W-1:0]  cmd_addr_o;
  logic [AMM_BURST_W-2:0] cmd_words_o;
  logic                   phase_done_i;

  modport master (
    output cmd_valid_o,
    output cmd_write_o,
    output cmd_addr_o,
    output cmd_words_o,
    input  cmd_ready_i,
    input  phase_done_i
  );

  modport slave (
    input  cmd_valid_o,
    input  cmd_write_o,
    input  cmd_addr_o,
    input  cmd_words_o,
    output cmd_ready_i,
    output phase_done_i
  );

endinterface

// File: rtl/mem_addr_gen.sv
// Address sequencer for the memory test: holds the current command address
// and advances it on each accepted command according to the address mode.
// A load restarts the sequence from the seed so a read phase can replay the
// exact address stream of the preceding write phase.
module mem_addr_gen
  import rtl_settings_pkg::*;
#(
  parameter int LFSR_W = CMP_ADDR_W
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   load,
  input  logic [CMP_ADDR_W-1:0]  seed,
  input  logic                   step,
  input  addr_mode_t             mode,
  input  logic [AMM_BURST_W-2:0] words,
  output logic [CMP_ADDR_W-1:0]  addr
);

  logic [CMP_ADDR_W-1:0] addr_reg;
  logic [CMP_ADDR_W-1:0] addr_next;
  logic [CMP_ADDR_W-1:0] walk;
  logic [CMP_ADDR_W-1:0] walk_next;
  logic [LFSR_W-1:0]     lfsr;
  logic [LFSR_W-1:0]     lfsr_next;
  logic [LFSR_W-1:0]     lfsr_seed;

  // An all-zero LFSR state would lock up, so a zero seed starts at 1.
  assign lfsr_seed = (LFSR_W'(seed) == '0) ? LFSR_W'(1) : LFSR_W'(seed);

  assign lfsr_next = {1'b0, lfsr[LFSR_W-1:1]} ^ (lfsr[0] ? LFSR_W'(LFSR_TAPS) : '0);

  // Walking pattern for the RUN modes: a single 1 rotating left, wrapping.
  assign walk_next = {walk[CMP_ADDR_W-2:0], walk[CMP_ADDR_W-1]};

  // Next address for the active mode.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    addr_next = addr_reg;
    case (mode)
      FIX:     addr_next = addr_reg;
      INC:     addr_next = addr_reg + CMP_ADDR_W'(words) + CMP_ADDR_W'(1);
      RND:     addr_next = CMP_ADDR_W'(lfsr_next);
      RUN_0:   addr_next = ~walk;
      RUN_1:   addr_next = walk;
      default: addr_next = addr_reg;
    endcase
  end

  // Address, LFSR and walking-bit registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
      addr_reg <= '0;
      lfsr     <= LFSR_W'(1);
      walk     <= CMP_ADDR_W'(1);
    end else if (load) begin
      addr_reg <= seed;
      lfsr     <= lfsr_seed;
      walk     <= CMP_ADDR_W'(1);
    end else if (step) begin
      addr_reg <= addr_next;
      if (mode == RND) begin
        lfsr <= lfsr_next;
      end
      if (mode == RUN_0 || mode == RUN_1) begin
        walk <= walk_next;
      end
    end
  end

  assign addr = addr_reg;

endmodule

// File: rtl/mem_test_ctrl.sv
// Memory test controller: on a start pulse it captures the test settings and
// issues a write phase, a read phase, or a write phase followed by a read
// phase that replays the same address stream. Commands leave on a
// valid/ready bus; each phase waits for phase_done before moving on.
// Optional feature: define MEM_TEST_CTRL_ABORT_EN to add abort_i/aborted_o,
// which end a running test early once no command is left hanging.
module mem_test_ctrl
  import rtl_settings_pkg::*;
#(
  parameter int TRANS_CNT_W = 16,
  parameter int LFSR_W      = CMP_ADDR_W
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  test_mode_t             test_mode_i,
  input  addr_mode_t             addr_mode_i,
  input  logic [TRANS_CNT_W-1:0] trans_cnt_i,
  input  logic [AMM_BURST_W-2:0] words_cnt_i,
  input  logic [CMP_ADDR_W-1:0]  base_addr_i,
`ifdef MEM_TEST_CTRL_ABORT_EN
  input  logic                   abort_i,
  output logic                   aborted_o,
`endif
  mem_test_ctrl_if.master        cmd,
  output logic                   busy_o,
  output logic                   test_finish_o
);

  mem_test_state_t        state;
  mem_test_state_t        state_next;

  // Settings captured at start and held for the whole test.
  test_mode_t             test_mode;
  addr_mode_t             addr_mode;
  logic [TRANS_CNT_W-1:0] trans_cnt;
  logic [AMM_BURST_W-2:0] words_cnt;
  logic [CMP_ADDR_W-1:0]  base_addr;

  logic [TRANS_CNT_W-1:0] cnt;
  logic                   issue;
  logic                   handshake;
  logic                   start_go;
  logic                   reload;
  logic                   gen_load;
  logic [CMP_ADDR_W-1:0]  gen_seed;
  logic [CMP_ADDR_W-1:0]  addr;

`ifdef MEM_TEST_CTRL_ABORT_EN
  logic                   abort_pend;
  logic                   abort_take;
  logic                   aborted;
`endif

  assign issue     = (state == WR_ISSUE) || (state == RD_ISSUE);
  assign handshake = issue && cmd.cmd_ready_i;
  assign start_go  = (state == IDLE) && start_i;

  // The generator is seeded from the live input at start and from the
  // captured copy when the read phase replays the write sequence.
  assign gen_load  = start_go || reload;
  assign gen_seed  = start_go ? base_addr_i : base_addr;

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode; also flags the write-to-read reload.
  always_comb begin
    state_next = state;
    reload     = 1'b0;
`ifdef MEM_TEST_CTRL_ABORT_EN
    abort_take = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (start_i) begin
          if (trans_cnt_i == '0) begin
            state_next = FINISH;
          end else if (test_mode_i == READ_ONLY) begin
            state_next = RD_ISSUE;
          end else begin
            state_next = WR_ISSUE;
          end
        end
      end
      WR_ISSUE: begin
        if (handshake && cnt == TRANS_CNT_W'(1)) begin
          state_next = WR_WAIT;
        end
      end
      WR_WAIT: begin
        if (cmd.phase_done_i) begin
          if (test_mode == WRITE_AND_CHECK) begin
            state_next = RD_ISSUE;
            reload     = 1'b1;
          end else begin
            state_next = FINISH;
          end
        end
      end
      RD_ISSUE: begin
        if (handshake && cnt == TRANS_CNT_W'(1)) begin
          state_next = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (cmd.phase_done_i) begin
          state_next = FINISH;
        end
      end
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
`ifdef MEM_TEST_CTRL_ABORT_EN
    // An abort must not strand an offered command: it waits for the
    // handshake while a command is on the bus.
    if (state != IDLE && state != FINISH && (abort_i || abort_pend) &&
        (!issue || cmd.cmd_ready_i)) begin
      state_next = FINISH;
      reload     = 1'b0;
      abort_take = 1'b1;
    end
`endif
  end

  // Settings capture and per-phase transaction counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      test_mode <= READ_ONLY;
      addr_mode <= FIX;
      trans_cnt <= '0;
      words_cnt <= '0;
      base_addr <= '0;
      cnt       <= '0;
    end else if (start_go) begin
      test_mode <= test_mode_i;
      addr_mode <= addr_mode_i;
      trans_cnt <= trans_cnt_i;
      words_cnt <= words_cnt_i;
      base_addr <= base_addr_i;
      cnt       <= trans_cnt_i;
    end else if (reload) begin
      cnt <= trans_cnt;
    end else if (handshake) begin
      cnt <= cnt - TRANS_CNT_W'(1);
    end
  end

`ifdef MEM_TEST_CTRL_ABORT_EN
  // Abort bookkeeping: remember an abort that is waiting for a handshake,
  // and flag a test that ended through abort until the next start.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      abort_pend <= 1'b0;
      aborted    <= 1'b0;
    end else begin
      if (state == IDLE || state == FINISH || abort_take) begin
        abort_pend <= 1'b0;
      end else if (abort_i) begin
        abort_pend <= 1'b1;
      end
      if (start_go) begin
        aborted <= 1'b0;
      end else if (abort_take) begin
        aborted <= 1'b1;
      end
    end
  end

  assign aborted_o = aborted;
`endif

  mem_addr_gen #(
    .LFSR_W (LFSR_W)
  ) u_addr_gen (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .load  (gen_load),
    .seed  (gen_seed),
    .step  (handshake),
    .mode  (addr_mode),
    .words (words_cnt),
    .addr  (addr)
  );

  assign cmd.cmd_valid_o = issue;
  assign cmd.cmd_write_o = (state == WR_ISSUE);
  assign cmd.cmd_addr_o  = addr;
  assign cmd.cmd_words_o = words_cnt;
  assign busy_o          = (state != IDLE);
  assign test_finish_o   = (state == FINISH);

endmodule
